// File: rtl/bmc_soft_pipe.sv
// Branch-metric unit: per-bit hard/soft/erased costs, all 2^N hypothesis sums and the
// best hypothesis, delivered through a 3-stage valid/ready pipeline.
module bmc_soft_pipe #(
  parameter  int N    = 2,
  parameter  int SW   = 3,
  parameter  int CW   = 16,
  localparam int SMAX = (1 << SW) - 1,
  localparam int MW   = $clog2(N * SMAX + 1),
  localparam int H    = 1 << N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*SW-1:0] rx_soft,
  input  logic [N-1:0]    erase,
  input  logic            hard_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [H*MW-1:0] bm_all,
  output logic [MW-1:0]   bm_min,
  output logic [N-1:0]    bm_min_idx,
  output logic [CW-1:0]   sym_cnt
);

  localparam logic [SW-1:0] SMAX_V = SW'(SMAX);

  logic            r_v1, r_v2, r_v3;
  logic            w_ld2, w_ld3, w_acc;
  logic [SW-1:0]   w_c0 [N];
  logic [SW-1:0]   w_c1 [N];
  logic [SW-1:0]   r_c0 [N];
  logic [SW-1:0]   r_c1 [N];
  logic [MW-1:0]   w_sum [H];
  logic [MW-1:0]   r_sum [H];
  logic [MW-1:0]   w_min;
  logic [N-1:0]    w_idx;
  logic [H*MW-1:0] r_bm_all;
  logic [MW-1:0]   r_bm_min;
  logic [N-1:0]    r_bm_min_idx;
  logic [CW-1:0]   r_sym_cnt;

  assign w_ld3    = !r_v3 || out_ready;
  assign w_ld2    = !r_v2 || w_ld3;
  assign in_ready = !flush && (!r_v1 || w_ld2);
  assign w_acc    = in_valid && in_ready;

  assign out_valid  = r_v3;
  assign bm_all     = r_bm_all;
  assign bm_min     = r_bm_min;
  assign bm_min_idx = r_bm_min_idx;
  assign sym_cnt    = r_sym_cnt;

  // Cost of each code bit under both expected values (c0: e=0, c1: e=1).
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_c0[i] = '0;
      w_c1[i] = '0;
      if (!erase[i]) begin
        if (hard_mode) begin
          w_c0[i] = SW'(rx_soft[i*SW + SW - 1]);
          w_c1[i] = SW'(!rx_soft[i*SW + SW - 1]);
        end else begin
          w_c0[i] = rx_soft[i*SW +: SW];
          w_c1[i] = SMAX_V - rx_soft[i*SW +: SW];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned h = 0; h < H; h++) begin
      w_sum[h] = '0;
      for (int unsigned i = 0; i < N; i++) begin
        if (((h >> i) & 32'd1) != 32'd0) w_sum[h] = w_sum[h] + MW'(r_c1[i]);
        else                             w_sum[h] = w_sum[h] + MW'(r_c0[i]);
      end
    end
  end

  // Strict compare while scanning upward keeps the lowest index on ties.
  always_comb begin
    w_min = r_sum[0];
    w_idx = '0;
    for (int unsigned h = 1; h < H; h++) begin
      if (r_sum[h] < w_min) begin
        w_min = r_sum[h];
        w_idx = N'(h);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (flush) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (in_ready) r_v1 <= in_valid;
      if (w_ld2)    r_v2 <= r_v1;
      if (w_ld3)    r_v3 <= r_v2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_c0[i] <= '0;
        r_c1[i] <= '0;
      end
      for (int unsigned h = 0; h < H; h++) r_sum[h] <= '0;
      r_bm_all     <= '0;
      r_bm_min     <= '0;
      r_bm_min_idx <= '0;
      r_sym_cnt    <= '0;
    end else if (!flush) begin
      if (w_acc) begin
        for (int unsigned i = 0; i < N; i++) begin
          r_c0[i] <= w_c0[i];
          r_c1[i] <= w_c1[i];
        end
      end
      if (w_ld2 && r_v1) begin
        for (int unsigned h = 0; h < H; h++) r_sum[h] <= w_sum[h];
      end
      if (w_ld3 && r_v2) begin
        for (int unsigned h = 0; h < H; h++) r_bm_all[h*MW +: MW] <= r_sum[h];
        r_bm_min     <= w_min;
        r_bm_min_idx <= w_idx;
      end
      if (r_v3 && out_ready) r_sym_cnt <= r_sym_cnt + 1'b1;
    end
  end

endmodule
